// File: rtl/ex_muldiv_pkg.sv
// Shared opcode/funct constants and state type for the EX-stage multiply/divide unit.
package ex_muldiv_pkg;

  localparam logic [5:0] RTYPE  = 6'h00;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  // Any HI/LO-touching op; these are the ones that must wait for a running operation.
  function automatic logic is_muldiv_funct(input logic [5:0] f);
    return (f == F_MFHI) || (f == F_MTHI) || (f == F_MFLO) || (f == F_MTLO) ||
           (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
  endfunction

  function automatic logic is_start_funct(input logic [5:0] f);
    return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
  endfunction

endpackage

// File: rtl/ex_muldiv_iter.sv
// One-bit-per-cycle datapath: radix-2 shift-add multiply and restoring divide on magnitudes.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_load,
  input  logic                 i_step,
  input  logic                 i_is_div,
  input  logic [WIDTH-1:0]     i_a_mag,
  input  logic [WIDTH-1:0]     i_b_mag,
  output logic [2*WIDTH-1:0]   o_acc_next
);

  // r_acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic               r_is_div;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shl_hi;
  logic [WIDTH:0]     w_diff;

  always_comb begin
    w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};
    w_shl_hi = r_acc[2*WIDTH-1:WIDTH-1];
    w_diff   = w_shl_hi - {1'b0, r_opnd};
    o_acc_next = {1'b0, r_acc[2*WIDTH-1:1]};
    if (r_is_div) begin
      // Borrow out of the trial subtract means the divisor did not fit: restore.
      if (!w_diff[WIDTH]) o_acc_next = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
      else                o_acc_next = {w_shl_hi[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
    end else if (r_acc[0]) begin
      o_acc_next = {w_sum, r_acc[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_opnd   <= '0;
      r_is_div <= 1'b0;
    end else if (i_load) begin
      r_acc    <= {{WIDTH{1'b0}}, (i_is_div ? i_a_mag : i_b_mag)};
      r_opnd   <= i_is_div ? i_b_mag : i_a_mag;
      r_is_div <= i_is_div;
    end else if (i_step) begin
      r_acc    <= o_acc_next;
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage HI/LO unit: op decode, stall generation, iteration FSM and signed fix-up on the final write.
//   state  | meaning
//   IDLE   | no operation in flight; MT*/MF* and new starts accepted
//   RUN    | iterating, r_cnt = step index 0..WIDTH-1; HI/LO ops stall
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_hi, r_lo, r_rs;
  logic               r_is_div, r_signed, r_sa, r_sb, r_b_zero;
  logic               w_rtype, w_busy, w_start, w_op_div, w_op_signed, w_neg;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_quo, w_rem, w_hi_fin, w_lo_fin;
  logic [2*WIDTH-1:0] w_acc_next, w_prod;

  assign w_busy      = (r_state == S_RUN);
  assign busy        = w_busy;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign w_rtype     = valid && (opcode == RTYPE);
  assign stall       = rst_n && w_busy && w_rtype && is_muldiv_funct(funct);
  assign w_start     = w_rtype && !w_busy && !flush && is_start_funct(funct);
  assign w_op_div    = (funct == F_DIV) || (funct == F_DIVU);
  assign w_op_signed = (funct == F_MULT) || (funct == F_DIV);
  assign w_a_mag     = (w_op_signed && rs_data[WIDTH-1]) ? -rs_data : rs_data;
  assign w_b_mag     = (w_op_signed && rt_data[WIDTH-1]) ? -rt_data : rt_data;

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_start),
    .i_step     (w_busy),
    .i_is_div   (w_op_div),
    .i_a_mag    (w_a_mag),
    .i_b_mag    (w_b_mag),
    .o_acc_next (w_acc_next)
  );

  always_comb begin
    result = '0;
    if (rst_n && w_rtype && !stall) begin
      if (funct == F_MFHI)      result = r_hi;
      else if (funct == F_MFLO) result = r_lo;
    end
  end

  // Sign fix-up works on the final step's combinational output so the write costs no extra cycle.
  always_comb begin
    w_neg  = r_signed && (r_sa ^ r_sb);
    w_prod = w_neg ? -w_acc_next : w_acc_next;
    w_quo  = w_neg ? -w_acc_next[WIDTH-1:0] : w_acc_next[WIDTH-1:0];
    w_rem  = (r_signed && r_sa) ? -w_acc_next[2*WIDTH-1:WIDTH] : w_acc_next[2*WIDTH-1:WIDTH];
    if (!r_is_div) begin
      w_hi_fin = w_prod[2*WIDTH-1:WIDTH];
      w_lo_fin = w_prod[WIDTH-1:0];
    end else if (r_b_zero) begin
      w_hi_fin = r_rs;
      w_lo_fin = '1;
    end else begin
      w_hi_fin = w_rem;
      w_lo_fin = w_quo;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_rs     <= '0;
      r_is_div <= 1'b0;
      r_signed <= 1'b0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_b_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_rtype && !flush) begin
            if (funct == F_MTHI) r_hi <= rs_data;
            if (funct == F_MTLO) r_lo <= rs_data;
          end
          if (w_start) begin
            r_state  <= S_RUN;
            r_cnt    <= '0;
            r_rs     <= rs_data;
            r_is_div <= w_op_div;
            r_signed <= w_op_signed;
            r_sa     <= rs_data[WIDTH-1];
            r_sb     <= rt_data[WIDTH-1];
            r_b_zero <= (rt_data == '0);
          end
        end
        S_RUN: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else if (r_cnt == LAST_STEP) begin
            r_state <= S_IDLE;
            r_hi    <= w_hi_fin;
            r_lo    <= w_lo_fin;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed corner cases plus random traffic against an arithmetic model.
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, valid, flush;
  logic [5:0]  opcode, funct;
  logic [31:0] rs_data, rt_data;
  logic        busy, stall;
  logic [31:0] result, hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: architectural HI/LO, cycles of busy left, and the values the pending op will write.
  logic [31:0] m_hi = '0, m_lo = '0, m_pend_hi = '0, m_pend_lo = '0;
  int          m_left = 0;

  logic        s_busy, s_stall;
  logic [31:0] s_result;

  ex_muldiv #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (valid),
    .opcode  (opcode),
    .funct   (funct),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .flush   (flush),
    .busy    (busy),
    .stall   (stall),
    .result  (result),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_checks++;
    if (obs !== req) begin
      n_fail++;
      $display("FAIL %s observed=%h required=%h", tag, obs, req);
    end
  endtask

  function automatic logic hilo_op(input logic [5:0] f);
    return f inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU};
  endfunction

  function automatic void ref_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] h, output logic [31:0] l);
    longint          sa, sb, sp;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    h = '0;
    l = '0;
    case (f)
      F_MULT:  begin sp = sa * sb; h = sp[63:32]; l = sp[31:0]; end
      F_MULTU: begin up = ua * ub; h = up[63:32]; l = up[31:0]; end
      F_DIV: begin
        if (b == 0) begin h = a; l = 32'hFFFF_FFFF; end
        else begin sp = sa / sb; l = sp[31:0]; sp = sa % sb; h = sp[31:0]; end
      end
      F_DIVU: begin
        if (b == 0) begin h = a; l = 32'hFFFF_FFFF; end
        else begin up = ua / ub; l = up[31:0]; up = ua % ub; h = up[31:0]; end
      end
      default: ;
    endcase
  endfunction

  // One clock cycle: drive, check outputs mid-cycle against the model, then advance the model.
  task automatic cyc(input logic v, input logic [5:0] op, input logic [5:0] fn,
                     input logic [31:0] a, input logic [31:0] b, input logic fl, input logic rn);
    logic        rt, e_busy, e_stall;
    logic [31:0] e_res, ph, pl;
    valid = v; opcode = op; funct = fn; rs_data = a; rt_data = b; flush = fl; rst_n = rn;
    rt      = v && (op == RTYPE);
    e_busy  = (m_left != 0);
    e_stall = rn && e_busy && rt && hilo_op(fn);
    e_res   = '0;
    if (rn && rt && !e_stall) begin
      if (fn == F_MFHI)      e_res = m_hi;
      else if (fn == F_MFLO) e_res = m_lo;
    end
    @(negedge clk);
    s_busy = busy; s_stall = stall; s_result = result;
    check_eq("busy",   {31'b0, busy},  {31'b0, e_busy});
    check_eq("stall",  {31'b0, stall}, {31'b0, e_stall});
    check_eq("result", result, e_res);
    check_eq("hi", hi, m_hi);
    check_eq("lo", lo, m_lo);
    @(posedge clk);
    if (!rn) begin
      m_hi = '0; m_lo = '0; m_left = 0;
    end else if (e_busy) begin
      if (fl) m_left = 0;
      else if (m_left == 1) begin m_hi = m_pend_hi; m_lo = m_pend_lo; m_left = 0; end
      else m_left--;
    end else if (rt && !fl) begin
      if (fn == F_MTHI) m_hi = a;
      if (fn == F_MTLO) m_lo = a;
      if (fn inside {F_MULT, F_MULTU, F_DIV, F_DIVU}) begin
        ref_op(fn, a, b, ph, pl);
        m_pend_hi = ph; m_pend_lo = pl; m_left = 32;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, RTYPE, F_MFLO, $urandom, $urandom, 1'b0, 1'b1);
  endtask

  // Issue one op, let it run with operands changing underneath, and count busy cycles seen.
  task automatic run_op(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b, input string tag);
    int nb;
    nb = 0;
    cyc(1'b1, RTYPE, fn, a, b, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      cyc(1'b0, RTYPE, F_MULT, $urandom, $urandom, 1'b0, 1'b1);
      if (s_busy) nb++;
      if (!busy) break;
    end
    check_eq({tag, "_busy_cycles"}, nb, 32);
  endtask

  initial begin
    int          nst;
    logic        done;
    logic [5:0]  fset [8];
    logic [31:0] specials [5];
    logic [5:0]  fn, op;
    logic [31:0] a, b;
    fset = '{F_MFHI, F_MTHI, F_MFLO, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU};
    specials = '{32'h0, 32'h1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};

    rst_n = 1'b0; valid = 1'b0; opcode = '0; funct = '0; rs_data = '0; rt_data = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cyc(1'b1, RTYPE, F_MFHI, 32'h1, 32'h2, 1'b0, 1'b0);
    check_eq("rst_result", s_result, 32'h0);
    check_eq("rst_hi", hi, 32'h0);

    cyc(1'b1, RTYPE, F_MTHI, 32'h0000_1234, 32'h0, 1'b0, 1'b1);
    cyc(1'b1, RTYPE, F_MTLO, 32'h0000_5678, 32'h0, 1'b0, 1'b1);
    check_eq("mt_hi", hi, 32'h0000_1234);
    check_eq("mt_lo", lo, 32'h0000_5678);
    cyc(1'b1, RTYPE, F_MFLO, 32'h0, 32'h0, 1'b0, 1'b1);
    check_eq("mflo_idle", s_result, 32'h0000_5678);

    run_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu");
    check_eq("multu_hi", hi, 32'hFFFF_FFFE);
    check_eq("multu_lo", lo, 32'h0000_0001);
    run_op(F_MULT, 32'hFFFF_FFFD, 32'h0000_0007, "mult");
    check_eq("mult_hi", hi, 32'hFFFF_FFFF);
    check_eq("mult_lo", lo, 32'hFFFF_FFEB);
    run_op(F_DIV, 32'hFFFF_FFF9, 32'h0000_0002, "div");
    check_eq("div_lo", lo, 32'hFFFF_FFFD);
    check_eq("div_hi", hi, 32'hFFFF_FFFF);
    run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "divovf");
    check_eq("divovf_lo", lo, 32'h8000_0000);
    check_eq("divovf_hi", hi, 32'h0);
    run_op(F_DIVU, 32'h5, 32'h0, "divz");
    check_eq("divz_lo", lo, 32'hFFFF_FFFF);
    check_eq("divz_hi", hi, 32'h5);

    // MFLO presented from the second busy cycle onward waits out the rest of the divide.
    cyc(1'b1, RTYPE, F_DIVU, 32'd100, 32'd7, 1'b0, 1'b1);
    idle(1);
    nst = 0; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      cyc(1'b1, RTYPE, F_MFLO, $urandom, $urandom, 1'b0, 1'b1);
      if (s_stall) nst++;
      else done = 1'b1;
    end
    check_eq("mflo_stall_cycles", nst, 31);
    check_eq("mflo_after_div", s_result, 32'd14);

    cyc(1'b1, RTYPE, F_MTHI, 32'h0000_1234, 32'h0, 1'b0, 1'b1);
    cyc(1'b1, RTYPE, F_MTLO, 32'h0000_5678, 32'h0, 1'b0, 1'b1);
    cyc(1'b1, RTYPE, F_MULT, 32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1);
    idle(9);
    cyc(1'b0, RTYPE, F_MFHI, 32'h0, 32'h0, 1'b1, 1'b1);
    check_eq("flush10_busy", {31'b0, busy}, 32'h0);
    check_eq("flush10_hi", hi, 32'h0000_1234);
    check_eq("flush10_lo", lo, 32'h0000_5678);

    cyc(1'b1, RTYPE, F_MULT, 32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1);
    idle(31);
    cyc(1'b0, RTYPE, F_MFHI, 32'h0, 32'h0, 1'b1, 1'b1);
    check_eq("flushlast_busy", {31'b0, busy}, 32'h0);
    check_eq("flushlast_lo", lo, 32'h0000_5678);

    cyc(1'b1, RTYPE, F_MTHI, 32'hDEAD_BEEF, 32'h0, 1'b1, 1'b1);
    check_eq("flushidle_mthi", hi, 32'h0000_1234);
    cyc(1'b1, RTYPE, F_DIV, 32'h7, 32'h2, 1'b1, 1'b1);
    check_eq("flushidle_start", {31'b0, busy}, 32'h0);

    cyc(1'b1, RTYPE, F_MULT, 32'h0000_0009, 32'h0000_0009, 1'b0, 1'b1);
    idle(5);
    cyc(1'b0, RTYPE, F_MFHI, 32'h0, 32'h0, 1'b0, 1'b0);
    check_eq("rstrun_busy", {31'b0, busy}, 32'h0);
    check_eq("rstrun_hi", hi, 32'h0);
    check_eq("rstrun_lo", lo, 32'h0);
    cyc(1'b1, RTYPE, F_MTHI, 32'hA5A5_A5A5, 32'h0, 1'b0, 1'b1);
    check_eq("rstrun_mthi", hi, 32'hA5A5_A5A5);
    cyc(1'b1, RTYPE, F_MFHI, 32'h0, 32'h0, 1'b0, 1'b1);
    check_eq("mfhi_idle", s_result, 32'hA5A5_A5A5);

    for (int i = 0; i < 3000; i++) begin
      fn = ($urandom_range(9) == 0) ? 6'($urandom) : fset[$urandom_range(7)];
      op = ($urandom_range(15) == 0) ? 6'($urandom) : RTYPE;
      a  = ($urandom_range(3) == 0) ? specials[$urandom_range(4)] : $urandom;
      b  = ($urandom_range(3) == 0) ? specials[$urandom_range(4)] : $urandom;
      cyc($urandom_range(9) < 7, op, fn, a, b, $urandom_range(39) == 0, $urandom_range(299) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 The block SHALL have a single clock and synchronous, active-low reset; ports SHALL be named clk and rst_n.
REQ-002 Parameter: WIDTH, default 32, operand/HI/LO width (only 32 is required to work).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 valid  input  1  EX-stage instruction present this cycle.
REQ-006 opcode  input  6  instruction opcode.
REQ-007 funct  input  6  instruction funct field.
REQ-008 rs_data  input  32  dividend/multiplicand/MTHI-MTLO source.
REQ-009 rt_data  input  32  divisor/multiplier.
REQ-010 flush  input  1  kill in-flight operation (branch/exception).
REQ-011 busy  output  1  iterative operation in progress.
REQ-012 stall  output  1  hold EX and upstream stages this cycle.
REQ-013 result  output  32  MFHI/MFLO read data.
REQ-014 hi, lo  output  32 each  architectural HI/LO registers.

Function
REQ-015 Ops decoded only when valid=1 and opcode=RTYPE: MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13, MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B; any other opcode/funct is a no-op.
REQ-016 FSM states: IDLE, RUN; IDLE->RUN on accepted MULT/MULTU/DIV/DIVU; RUN->IDLE after iteration 31 or on flush.
REQ-017 A start is accepted only in IDLE with stall=0; the cycle counter SHALL load 0 at acceptance and increment once per RUN cycle.
REQ-018 busy SHALL be 1 for exactly 32 cycles following the acceptance edge; HI/LO SHALL be written at the edge ending the 32nd busy cycle.
REQ-019 Multiply: radix-2 shift-add on magnitudes, one bit per cycle, 64-bit product; HI=product[63:32], LO=product[31:0].
REQ-020 Divide: restoring, one quotient bit per cycle on magnitudes; LO=quotient, HI=remainder.
REQ-021 Signed ops: quotient negative iff operand signs differ; remainder takes dividend sign; product negative iff signs differ; sign fix-up applied in the final write, no extra cycle.
REQ-022 Signed overflow 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0.
REQ-023 Divide by zero (DIV or DIVU) SHALL yield LO=0xFFFFFFFF, HI=rs_data as captured.
REQ-024 Operands SHALL be captured at acceptance; later rs_data/rt_data changes have no effect.
REQ-025 stall SHALL be combinational: 1 when busy=1 and valid RTYPE funct is any of the eight ops in REQ-015; else 0.
REQ-026 In the last RUN cycle stall SHALL still be 1; a stalled op SHALL be re-presented and accepted the following cycle.
REQ-027 MFHI/MFLO when not stalled: result=hi/lo combinationally the same cycle; result=0 otherwise.
REQ-028 MTHI/MTLO when not stalled: hi/lo=rs_data at the next edge, one cycle, busy unaffected.
REQ-029 flush SHALL take priority over all: in RUN, return to IDLE next edge, HI/LO unchanged; in IDLE, suppress acceptance and MTHI/MTLO writes that cycle.
REQ-030 flush asserted in the final RUN cycle SHALL suppress the HI/LO write.

Reset
REQ-031 On rst_n=0 at a clock edge: state=IDLE, counter=0, hi=0, lo=0, busy=0; reset mid-operation aborts without HI/LO write.
REQ-032 stall and result SHALL be 0 while rst_n=0.

Structure
REQ-033 RTYPE and the eight funct codes SHALL live in the shared opcode constants include; no local literals.
REQ-034 One sub-module, muldiv_iter, SHALL hold the shift/add/subtract datapath; FSM, decode, sign fix-up and HI/LO in ex_muldiv.

Verification
REQ-035 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 32 busy cycles HI=0xFFFFFFFE, LO=0x00000001.
REQ-036 MULT 0xFFFFFFFD x 0x00000007 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; DIV 0xFFFFFFF9 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-037 DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0; DIVU 5 / 0 -> LO=0xFFFFFFFF, HI=5.
REQ-038 MFLO issued 1 cycle after DIVU start -> stall=1 for 31 cycles, then result=new LO with stall=0.
REQ-039 flush at busy cycle 10 of MULT with HI=0x1234, LO=0x5678 -> busy=0 next cycle, HI/LO unchanged.
REQ-040 rst_n=0 during RUN -> next edge busy=0, hi=lo=0; subsequent MTHI 0xA5A5A5A5 -> hi=0xA5A5A5A5 one cycle later.
